// File: rtl/qdec_pkg.sv
// Shared constants and the phase-pair decode function for the quadrature decoder.
package qdec_pkg;

  // Quadrature phase encodings as {A,B}
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Direction encodings for UpOrDown
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Result of classifying one {prev,ph} pair
  typedef struct packed {
    logic valid;    // a single-bit, legal phase step
    logic dir;      // DIR_UP or DIR_DOWN, meaningful only when valid
    logic illegal;  // both phases changed at once
  } qdec_step_t;

  // Classify a transition from prev to ph; equal phases give all-zero
  function automatic qdec_step_t qdec_step(input logic [1:0] prev, input logic [1:0] ph);
    qdec_step_t r;
    r = '0;
    case ({prev, ph})
      {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: begin
        r.valid = 1'b1;
        r.dir   = DIR_UP;
      end
      {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: begin
        r.valid = 1'b1;
        r.dir   = DIR_DOWN;
      end
      {PH_00, PH_11}, {PH_11, PH_00}, {PH_01, PH_10}, {PH_10, PH_01}: begin
        r.illegal = 1'b1;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_sync.sv
// Multi-flop synchronizer for the asynchronous A/B phase inputs.
// SYNC_STAGES must be 2 or 3.
module quad_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  output logic [1:0] ph
);

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;

  // Shift each raw phase one stage deeper into its chain
  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b};
  end

  // Chain registers, cleared by the synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
    end
  end

  assign ph = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

endmodule

// File: rtl/quadrature_decoder.sv
// x4 quadrature decoder: synchronizes A/B, classifies each phase change and
// keeps a wrapping position count, last direction, step pulse and sticky error.
module quadrature_decoder
  import qdec_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             A,
  input  logic             B,
  input  logic             Clear,
  output logic [WIDTH-1:0] Count,
  output logic             UpOrDown,
  output logic             Step,
  output logic             Err
);

  // The arm window spans the synchronizer fill plus one cycle for prev to
  // pick up the first live phase, so the reset value 00 is never decoded.
  localparam int              ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [1:0]       ph;
  logic [1:0]       prev_q, prev_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             armed;
  qdec_step_t       step_info;

  quad_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (Clk),
    .reset(reset),
    .a    (A),
    .b    (B),
    .ph   (ph)
  );

  assign armed = (arm_cnt_q == ARM_DONE);

  // Next-state: Clear beats decode; decode only acts once armed
  always_comb begin
    step_info = qdec_step(prev_q, ph);
    prev_d    = ph;
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 1'b1;
    count_d   = count_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    err_d     = err_q;
    if (Clear) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if (armed) begin
      if (step_info.valid) begin
        count_d = (step_info.dir == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        dir_d   = step_info.dir;
        step_d  = 1'b1;
      end
      if (step_info.illegal) begin
        err_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!reset) begin
      prev_q    <= PH_00;
      arm_cnt_q <= '0;
      count_q   <= '0;
      dir_q     <= DIR_DOWN;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      arm_cnt_q <= arm_cnt_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      err_q     <= err_d;
    end
  end

  assign Count    = count_q;
  assign UpOrDown = dir_q;
  assign Step     = step_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: directed scenarios plus random
// phase traffic, compared every cycle against a position-index reference model.
module tb_quadrature_decoder;

  localparam int WIDTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int MODULUS     = 1 << WIDTH;

  logic             Clk = 1'b0;
  logic             reset;
  logic             A;
  logic             B;
  logic             Clear;
  logic [WIDTH-1:0] Count;
  logic             UpOrDown;
  logic             Step;
  logic             Err;

  int    testsRun    = 0;
  int    testsFailed = 0;
  string phaseName   = "init";

  // Reference model state
  int mCount = 0;
  int mDir   = 0;
  int mStep  = 0;
  int mErr   = 0;
  int mEdges = 0;
  int histQ[$];

  int posIdx     = 2;
  int stepPulses = 0;

  quadrature_decoder #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .Clk     (Clk),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .Clear   (Clear),
    .Count   (Count),
    .UpOrDown(UpOrDown),
    .Step    (Step),
    .Err     (Err)
  );

  // 10 ns clock
  always #5 Clk = ~Clk;

  // Position around the quadrature cycle 00,01,11,10
  function automatic logic [1:0] idxToGray(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int grayToIdx(input logic [1:0] ph);
    case (ph)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s/%s: got %0d, expected %0d", phaseName, tag, observed, expected);
    end
  endtask

  // Advance the model by one rising edge. A phase change captured at edge k
  // shows at edge k+SYNC_STAGES; the step is the signed distance moved
  // around the 4-position cycle. Changes captured before the decoder has a
  // valid previous phase (first SYNC_STAGES+1 edges after reset) are ignored.
  task automatic updateModel();
    int d;
    if (!reset) begin
      mCount = 0;
      mDir   = 0;
      mStep  = 0;
      mErr   = 0;
      mEdges = 0;
      histQ.delete();
    end else begin
      mEdges++;
      histQ.push_back(grayToIdx({A, B}));
      mStep = 0;
      if (Clear) begin
        mCount = 0;
        mErr   = 0;
      end else if (mEdges >= SYNC_STAGES + 2) begin
        d = (histQ[mEdges-1-SYNC_STAGES] - histQ[mEdges-2-SYNC_STAGES] + 4) % 4;
        if (d == 1) begin
          mCount = (mCount + 1) % MODULUS;
          mDir   = 1;
          mStep  = 1;
        end else if (d == 3) begin
          mCount = (mCount + MODULUS - 1) % MODULUS;
          mDir   = 0;
          mStep  = 1;
        end else if (d == 2) begin
          mErr = 1;
        end
      end
    end
  endtask

  // Drive one cycle on the falling edge, then check just after the rising edge
  task automatic applyStimulus(input bit rstVal, input bit clrVal);
    @(negedge Clk);
    reset  = rstVal;
    Clear  = clrVal;
    {A, B} = idxToGray(posIdx);
    @(posedge Clk);
    updateModel();
    #1;
    checkOutput("Count", Count, mCount);
    checkOutput("Step", Step, mStep);
    checkOutput("Err", Err, mErr);
    checkOutput("UpOrDown", UpOrDown, mDir);
    if (Step === 1'b1) stepPulses++;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0);
  endtask

  task automatic moveBy(input int delta);
    posIdx = (posIdx + delta + 4) % 4;
    applyStimulus(1'b1, 1'b0);
    idle(3);
  endtask

  initial begin
    reset  = 1'b0;
    Clear  = 1'b0;
    posIdx = 2;
    {A, B} = idxToGray(posIdx);

    // Reset held with A=B=1, then release and let arming pass
    phaseName = "reset";
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rstCount", Count, 0);
    checkOutput("rstUpOrDown", UpOrDown, 0);
    idle(6);
    checkOutput("armErr", Err, 0);
    checkOutput("armCount", Count, 0);

    // Restart from phase 00 and sweep 20 edges upward through the wrap
    phaseName = "upSweep";
    posIdx = 0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    idle(6);
    stepPulses = 0;
    for (int i = 0; i < 20; i++) moveBy(1);
    checkOutput("pulses", stepPulses, 20);
    checkOutput("finalCount", Count, 4);
    checkOutput("finalDir", UpOrDown, 1);

    // Down to 2, then four more down steps through the wrap
    phaseName = "downSweep";
    moveBy(-1);
    moveBy(-1);
    checkOutput("at2", Count, 2);
    for (int i = 0; i < 4; i++) moveBy(-1);
    checkOutput("finalCount", Count, 14);
    checkOutput("finalDir", UpOrDown, 0);

    // Reversal mid-sequence
    phaseName = "reversal";
    applyStimulus(1'b1, 1'b1);
    idle(3);
    moveBy(1);
    moveBy(1);
    checkOutput("peak", Count, 2);
    moveBy(-1);
    checkOutput("backDir", UpOrDown, 0);
    moveBy(-1);
    checkOutput("finalCount", Count, 0);

    // Illegal double-phase jump, sticky error, then Clear
    phaseName = "illegal";
    moveBy(2);
    checkOutput("errSet", Err, 1);
    checkOutput("countHeld", Count, 0);
    moveBy(1);
    moveBy(1);
    checkOutput("stillErr", Err, 1);
    checkOutput("stillCounts", Count, 2);
    applyStimulus(1'b1, 1'b1);
    checkOutput("clrCount", Count, 0);
    checkOutput("clrErr", Err, 0);
    idle(3);

    // Clear on the same edge where a step lands drops the step
    phaseName = "clearVsStep";
    posIdx = (posIdx + 1) % 4;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("dropped", Count, 0);
    idle(4);

    // Mid-operation reset; an edge inside the arming window is ignored
    phaseName = "midReset";
    for (int i = 0; i < 7; i++) moveBy(1);
    checkOutput("at7", Count, 7);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rstCount", Count, 0);
    moveBy(1);
    checkOutput("ignored", Count, 0);
    moveBy(1);
    checkOutput("nextCounts", Count, 1);

    // Random traffic, including back-to-back edges, Clear and reset
    phaseName = "random";
    for (int i = 0; i < 600; i++) begin
      int r;
      bit rst;
      bit clr;
      r = $urandom_range(0, 99);
      if (r < 30)      posIdx = (posIdx + 1) % 4;
      else if (r < 55) posIdx = (posIdx + 3) % 4;
      else if (r < 58) posIdx = (posIdx + 2) % 4;
      rst = ($urandom_range(0, 199) != 0);
      clr = ($urandom_range(0, 49) == 0);
      applyStimulus(rst, clr);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
